// File: rtl/match_log_capture.sv
// match_log_capture
//   Watches C_NUM_CH detector channels for new match events and logs each one,
//   with a timestamp, into a show-ahead FIFO that a consumer drains.
//   Each channel has a one-entry pending register. A round-robin arbiter moves
//   one pending entry per cycle into the FIFO. When the FIFO is full, the
//   overwrite input chooses between dropping the newest entry and overwriting
//   the oldest. Every lost event is counted in drop_count.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   enable            capture enable (detection still tracks ids when low)
//   overwrite         full policy: 0 = drop newest, 1 = overwrite oldest
//   clr_drops         synchronous clear of drop_count
//   current_time      64-bit timestamp, time_running marks it valid
//   match/match_id    per-channel match vector and event id
//   ext_num/ext_data  per-channel extracted byte count and data
//   out_valid/ready   FIFO head handshake; out_data = {ch, ext_data, ext_num, match, time}
//   occupancy         number of stored entries
//   drop_count        saturating count of lost events
module match_log_capture #(
  parameter int C_NUM_CH  = 2,
  parameter int C_MATCH_W = 4,
  parameter int C_EXT_W   = 128,
  parameter int C_DEPTH   = 16,
  localparam int CW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1,
  localparam int EW = CW + C_EXT_W + 5 + C_MATCH_W + 64,
  localparam int AW = $clog2(C_DEPTH),
  localparam int OW = AW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          overwrite,
  input  logic                          clr_drops,
  input  logic [63:0]                   current_time,
  input  logic                          time_running,
  input  logic [C_NUM_CH*C_MATCH_W-1:0] match,
  input  logic [C_NUM_CH*2-1:0]         match_id,
  input  logic [C_NUM_CH*5-1:0]         ext_num,
  input  logic [C_NUM_CH*C_EXT_W-1:0]   ext_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EW-1:0]                 out_data,
  output logic [OW-1:0]                 occupancy,
  output logic [31:0]                   drop_count
);

  localparam int PW = EW - CW;

  logic [1:0]          last_id   [C_NUM_CH];
  logic [C_NUM_CH-1:0] pend_v;
  logic [PW-1:0]       pend_data [C_NUM_CH];
  logic [CW-1:0]       rr_start;
  logic [EW-1:0]       mem       [C_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [31:0]         drop_cnt_q;

  logic [C_NUM_CH-1:0] det;
  logic [C_NUM_CH-1:0] qual;
  logic [C_NUM_CH-1:0] latch;
  logic [C_NUM_CH-1:0] overrun;
  logic [C_NUM_CH-1:0] gnt_oh;
  logic                grant_v;
  logic [CW-1:0]       grant_ch;
  logic                hi_v;
  logic [CW-1:0]       hi_ch;
  logic [CW-1:0]       lo_ch;
  logic                full;
  logic                pop;
  logic                fifo_wr;
  logic                fifo_drop;
  logic                ovw;
  logic [EW-1:0]       wr_entry;
  logic [31:0]         drop_inc;
  logic [32:0]         drop_sum;

  // Detection and pending-register bookkeeping. A channel being granted this
  // cycle frees its slot, so a new event can take that slot on the same edge.
  always_comb begin
    for (int i = 0; i < C_NUM_CH; i++) begin
      det[i]     = (match_id[i*2 +: 2] != last_id[i]) &&
                   (match[i*C_MATCH_W +: C_MATCH_W] != '0);
      qual[i]    = det[i] & enable & time_running;
      gnt_oh[i]  = grant_v && (grant_ch == CW'(i));
      latch[i]   = qual[i] & (~pend_v[i] | gnt_oh[i]);
      overrun[i] = qual[i] & pend_v[i] & ~gnt_oh[i];
    end
  end

  // Round-robin arbiter: pick the lowest pending channel at or above rr_start.
  // If there is none, wrap around to the lowest pending channel overall.
  always_comb begin
    hi_v  = 1'b0;
    hi_ch = '0;
    lo_ch = '0;
    for (int k = C_NUM_CH - 1; k >= 0; k--) begin
      if (pend_v[k]) begin
        lo_ch = CW'(k);
        if (CW'(k) >= rr_start) begin
          hi_v  = 1'b1;
          hi_ch = CW'(k);
        end
      end
    end
    grant_v  = |pend_v;
    grant_ch = hi_v ? hi_ch : lo_ch;
  end

  assign wr_entry  = {grant_ch, pend_data[grant_ch]};
  assign full      = (occupancy == OW'(C_DEPTH));
  assign out_valid = (occupancy != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  // Full with no pop: either the grant is discarded or the oldest entry is
  // pushed out. In both cases exactly one event is lost.
  assign fifo_drop = grant_v & full & ~pop;
  assign ovw       = fifo_drop & overwrite;
  assign fifo_wr   = grant_v & (~full | pop | overwrite);

  always_comb begin
    drop_inc = 32'(fifo_drop);
    for (int i = 0; i < C_NUM_CH; i++) begin
      drop_inc = drop_inc + 32'(overrun[i]);
    end
    drop_sum = {1'b0, drop_cnt_q} + {1'b0, drop_inc};
  end

  assign drop_count = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        last_id[i] <= '0;
      end
      pend_v     <= '0;
      rr_start   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (det[i]) begin
          last_id[i] <= match_id[i*2 +: 2];
        end
        if (latch[i]) begin
          pend_v[i] <= 1'b1;
        end else if (gnt_oh[i]) begin
          pend_v[i] <= 1'b0;
        end
      end

      if (grant_v) begin
        rr_start <= (grant_ch == CW'(C_NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
      end

      if (fifo_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // The overwrite case advances the read side too, which retires the
      // oldest entry.
      if (pop || ovw) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({fifo_wr & ~ovw, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase

      if (clr_drops) begin
        drop_cnt_q <= '0;
      end else if (drop_sum[32]) begin
        drop_cnt_q <= '1;
      end else begin
        drop_cnt_q <= drop_sum[31:0];
      end
    end
  end

  // Payload storage is not reset; only the valid and pointer state above is.
  always_ff @(posedge clk) begin
    for (int i = 0; i < C_NUM_CH; i++) begin
      if (!rst && latch[i]) begin
        pend_data[i] <= {ext_data[i*C_EXT_W +: C_EXT_W], ext_num[i*5 +: 5],
                         match[i*C_MATCH_W +: C_MATCH_W], current_time};
      end
    end
    if (!rst && fifo_wr) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_match_log_capture.sv
module tb_match_log_capture;
  localparam int N  = 2;
  localparam int MW = 4;
  localparam int XW = 128;
  localparam int D  = 16;
  localparam int CW = 1;
  localparam int EW = CW + XW + 5 + MW + 64;
  localparam int PW = EW - CW;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              overwrite;
  logic              clr_drops;
  logic [63:0]       current_time;
  logic              time_running;
  logic [N*MW-1:0]   match;
  logic [N*2-1:0]    match_id;
  logic [N*5-1:0]    ext_num;
  logic [N*XW-1:0]   ext_data;
  logic              out_valid;
  logic              out_ready;
  logic [EW-1:0]     out_data;
  logic [$clog2(D):0] occupancy;
  logic [31:0]       drop_count;

  always #5 clk = ~clk;

  match_log_capture #(
    .C_NUM_CH(N), .C_MATCH_W(MW), .C_EXT_W(XW), .C_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .overwrite(overwrite),
    .clr_drops(clr_drops), .current_time(current_time),
    .time_running(time_running), .match(match), .match_id(match_id),
    .ext_num(ext_num), .ext_data(ext_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .drop_count(drop_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: event log as a queue, pending slots as plain arrays.
  logic [1:0]        m_last_id [N];
  bit                m_pv [N];
  logic [PW-1:0]     m_pd [N];
  int                m_rr;
  logic [EW-1:0]     m_q [$];
  longint unsigned   m_drops;

  task automatic model_step();
    int g;
    int drops;
    int c;
    logic [1:0] id;
    logic [MW-1:0] mv;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_last_id[i] = 2'd0;
        m_pv[i] = 1'b0;
      end
      m_rr = 0;
      m_q.delete();
      m_drops = 0;
      return;
    end
    g = -1;
    drops = 0;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (g < 0 && m_pv[c]) g = c;
    end
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      if (m_q.size() < D) begin
        m_q.push_back({CW'(g), m_pd[g]});
      end else begin
        drops++;
        if (overwrite) begin
          void'(m_q.pop_front());
          m_q.push_back({CW'(g), m_pd[g]});
        end
      end
      m_pv[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      id = match_id[i*2 +: 2];
      mv = match[i*MW +: MW];
      if (mv != '0 && id != m_last_id[i]) begin
        m_last_id[i] = id;
        if (enable && time_running) begin
          if (m_pv[i]) begin
            drops++;
          end else begin
            m_pv[i] = 1'b1;
            m_pd[i] = {ext_data[i*XW +: XW], ext_num[i*5 +: 5], mv, current_time};
          end
        end
      end
    end
    if (clr_drops) begin
      m_drops = 0;
    end else begin
      m_drops = m_drops + longint'(drops);
      if (m_drops > 64'hFFFF_FFFF) m_drops = 64'hFFFF_FFFF;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input int ch, input logic [1:0] id, input logic [MW-1:0] m,
                        input logic [63:0] t);
    match_id[ch*2 +: 2] = id;
    match[ch*MW +: MW]  = m;
    ext_num[ch*5 +: 5]  = 5'(ch + 3);
    ext_data[ch*XW +: XW] = {$urandom, $urandom, $urandom, $urandom};
    current_time = t;
  endtask

  task automatic do_reset();
    match    = '0;
    match_id = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    n_vec++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL reset_drops got=%0d want=0", drop_count); end
  endtask

  task automatic test_single_event();
    set_ev(0, 2'd1, 4'b0010, 64'd100);
    tick();
    match = '0;
    current_time = 64'd200;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early got=%0b want=0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    n_vec++; if (occupancy !== 5'd1) begin n_err++; $display("FAIL single_occ got=%0d want=1", occupancy); end
    n_vec++; if (out_data[63:0] !== 64'd100) begin n_err++; $display("FAIL single_time got=%0d want=100", out_data[63:0]); end
    n_vec++; if (out_data[64 +: MW] !== 4'd2) begin n_err++; $display("FAIL single_match got=%0d want=2", out_data[64 +: MW]); end
    n_vec++; if (out_data[EW-1 -: CW] !== 1'b0) begin n_err++; $display("FAIL single_ch got=%0d want=0", out_data[EW-1 -: CW]); end
    n_vec++; if (out_data[64+MW +: 5] !== 5'd3) begin n_err++; $display("FAIL single_extnum got=%0d want=3", out_data[64+MW +: 5]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_ev(0, 2'd1, 4'd1, 64'd300);
    set_ev(1, 2'd1, 4'd3, 64'd300);
    tick();
    match = '0;
    tick();
    n_vec++; if (occupancy !== 5'd1 || out_data[EW-1 -: CW] !== 1'b0) begin n_err++; $display("FAIL pair1_first occ=%0d ch=%0d want occ=1 ch=0", occupancy, out_data[EW-1 -: CW]); end
    tick();
    n_vec++; if (occupancy !== 5'd2) begin n_err++; $display("FAIL pair1_occ got=%0d want=2", occupancy); end
    out_ready = 1'b1;
    tick();
    n_vec++; if (occupancy !== 5'd1 || out_data[EW-1 -: CW] !== 1'b1) begin n_err++; $display("FAIL pair1_second occ=%0d ch=%0d want occ=1 ch=1", occupancy, out_data[EW-1 -: CW]); end
    tick();
    out_ready = 1'b0;
    // A lone ch0 event makes ch0 the most recent grant.
    set_ev(0, 2'd2, 4'd1, 64'd310);
    tick();
    match = '0;
    tick();
    n_vec++; if (occupancy !== 5'd1 || out_data[EW-1 -: CW] !== 1'b0) begin n_err++; $display("FAIL lone_ch0 occ=%0d ch=%0d want occ=1 ch=0", occupancy, out_data[EW-1 -: CW]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    set_ev(0, 2'd3, 4'd1, 64'd320);
    set_ev(1, 2'd2, 4'd1, 64'd320);
    tick();
    match = '0;
    tick();
    n_vec++; if (occupancy !== 5'd1 || out_data[EW-1 -: CW] !== 1'b1) begin n_err++; $display("FAIL pair2_first occ=%0d ch=%0d want occ=1 ch=1", occupancy, out_data[EW-1 -: CW]); end
    tick();
    out_ready = 1'b1;
    tick();
    n_vec++; if (occupancy !== 5'd1 || out_data[EW-1 -: CW] !== 1'b0) begin n_err++; $display("FAIL pair2_second occ=%0d ch=%0d want occ=1 ch=0", occupancy, out_data[EW-1 -: CW]); end
    tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pair2_drained got=%0b want=0", out_valid); end
  endtask

  task automatic fill_ch0(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      set_ev(0, 2'((k + 1) % 4), 4'd1, 64'(1000 + k));
      tick();
    end
    match = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_full_drop();
    do_reset();
    overwrite = 1'b0;
    out_ready = 1'b0;
    fill_ch0(0, 19);
    n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL drop_occ got=%0d want=16", occupancy); end
    n_vec++; if (drop_count !== 32'd3) begin n_err++; $display("FAIL drop_count got=%0d want=3", drop_count); end
    n_vec++; if (out_data[63:0] !== 64'd1000) begin n_err++; $display("FAIL drop_head got=%0d want=1000", out_data[63:0]); end
  endtask

  task automatic test_overrun();
    set_ev(1, 2'd1, 4'd1, 64'd2000);
    tick();
    set_ev(1, 2'd2, 4'd1, 64'd2001);
    tick();
    match = '0;
    tick();
    tick();
    tick();
    n_vec++; if (drop_count !== 32'd5) begin n_err++; $display("FAIL overrun_drops got=%0d want=5", drop_count); end
    enable = 1'b0;
    set_ev(1, 2'd3, 4'd1, 64'd2002);
    tick();
    set_ev(1, 2'd0, 4'd1, 64'd2003);
    tick();
    match = '0;
    enable = 1'b1;
    tick();
    tick();
    n_vec++; if (drop_count !== 32'd5) begin n_err++; $display("FAIL disabled_drops got=%0d want=5", drop_count); end
    n_vec++; if (occupancy !== 5'd16 || out_data[63:0] !== 64'd1000) begin n_err++; $display("FAIL overrun_fifo occ=%0d head=%0d want occ=16 head=1000", occupancy, out_data[63:0]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    n_vec++; if (occupancy !== 5'd5 || drop_count !== 32'd5) begin n_err++; $display("FAIL premid occ=%0d drops=%0d want occ=5 drops=5", occupancy, drop_count); end
    set_ev(0, 2'd1, 4'd1, 64'd3000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    match = '0;
    out_ready = 1'b0;
    n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL mid_occ got=%0d want=0", occupancy); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%0b want=0", out_valid); end
    n_vec++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL mid_drops got=%0d want=0", drop_count); end
  endtask

  task automatic test_full_overwrite();
    do_reset();
    overwrite = 1'b1;
    out_ready = 1'b0;
    fill_ch0(0, 19);
    n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL ovw_occ got=%0d want=16", occupancy); end
    n_vec++; if (drop_count !== 32'd3) begin n_err++; $display("FAIL ovw_drops got=%0d want=3", drop_count); end
    n_vec++; if (out_data[63:0] !== 64'd1003) begin n_err++; $display("FAIL ovw_head got=%0d want=1003", out_data[63:0]); end
    overwrite = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    overwrite = 1'b0;
    out_ready = 1'b0;
    fill_ch0(0, 16);
    n_vec++; if (occupancy !== 5'd16 || drop_count !== 32'd0) begin n_err++; $display("FAIL sat_pre occ=%0d drops=%0d want occ=16 drops=0", occupancy, drop_count); end
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    release dut.drop_cnt_q;
    m_drops = 64'hFFFF_FFFE;
    fill_ch0(16, 2);
    n_vec++; if (drop_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_drops got=%h want=ffffffff", drop_count); end
    clr_drops = 1'b1;
    tick();
    clr_drops = 1'b0;
    n_vec++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL clr_drops got=%0d want=0", drop_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst          = ($urandom_range(0, 299) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      time_running = ($urandom_range(0, 9) != 0);
      clr_drops    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) overwrite = ~overwrite;
      out_ready    = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) != 0);
      current_time = current_time + 64'($urandom_range(1, 5));
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          match_id[c*2 +: 2]    = 2'($urandom_range(0, 3));
          match[c*MW +: MW]     = MW'($urandom_range(0, 15));
          ext_num[c*5 +: 5]     = 5'($urandom_range(0, 31));
          ext_data[c*XW +: XW]  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      tick();
      n_vec++; if (out_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", cyc, out_valid, m_q.size() != 0); end
      n_vec++; if (occupancy !== 5'(m_q.size())) begin n_err++; $display("FAIL rnd_occ cyc=%0d got=%0d want=%0d", cyc, occupancy, m_q.size()); end
      n_vec++; if (drop_count !== m_drops[31:0]) begin n_err++; $display("FAIL rnd_drops cyc=%0d got=%0d want=%0d", cyc, drop_count, m_drops[31:0]); end
      if (m_q.size() != 0) begin
        n_vec++; if (out_data !== m_q[0]) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, out_data, m_q[0]); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    overwrite    = 1'b0;
    clr_drops    = 1'b0;
    time_running = 1'b1;
    out_ready    = 1'b0;
    current_time = '0;
    match        = '0;
    match_id     = '0;
    ext_num      = '0;
    ext_data     = '0;
    test_reset();
    test_single_event();
    test_simultaneous();
    test_full_drop();
    test_overrun();
    test_reset_mid();
    test_full_overwrite();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
